// File: rtl/weight_stream_fetcher.sv
// weight_stream_fetcher: reads a run of words from the parameter ROM bank and
// streams them out as valid/ready with a last flag, buffering up to FIFO_DEPTH
// words so consumer back-pressure never drops a ROM read.
module weight_stream_fetcher #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 18,
    parameter int LAYER_WIDTH = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LAYER_WIDTH-1:0] cmd_layer,
    input  logic [ADDR_WIDTH-1:0]  cmd_base,
    input  logic [ADDR_WIDTH-1:0]  cmd_len,
    output logic [LAYER_WIDTH-1:0] mem_layer_select,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [LAYER_WIDTH-1:0] layer_q, layer_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  remaining_q, remaining_d;
    logic                   inflight_q, inflight_d;
    logic                   infl_last_q, infl_last_d;
    logic                   done_q, done_d;

    logic [DATA_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic                   fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;

    logic                   cmd_fire;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   head_last;
    logic [CNT_W:0]         credit_used;

    // A read is only issued when its word is guaranteed a FIFO slot: words
    // already buffered plus the one still coming back from the ROM.
    assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign cmd_fire    = cmd_valid && (state_q == S_IDLE);
    assign issue       = (state_q == S_FETCH) && (credit_used < DEPTH_C);
    assign push        = inflight_q;
    assign pop         = out_valid && out_ready;
    assign head_last   = fifo_last_q[rd_ptr_q];

    assign cmd_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign mem_addr         = addr_q;
    assign mem_layer_select = layer_q;
    assign out_valid        = (count_q != '0);
    assign out_data         = fifo_data_q[rd_ptr_q];
    assign out_last         = out_valid && head_last;

    // Next-state logic: command latch, read issue under credit, drain to done.
    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = 1'b0;
        infl_last_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_len != '0) begin
                        layer_d     = cmd_layer;
                        addr_d      = cmd_base;
                        remaining_d = cmd_len;
                        state_d     = S_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (issue) begin
                    inflight_d  = 1'b1;
                    infl_last_d = (remaining_q == ADDR_WIDTH'(1));
                    remaining_d = remaining_q - ADDR_WIDTH'(1);
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    if (remaining_q == ADDR_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Layer select is left untouched here: the ROM output mux is
                // combinational on it and the final word may still be in flight.
                if (pop && head_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            layer_q     <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

    // Output FIFO: captures the ROM word one cycle after its address was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_data;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_stream_fetcher.sv
// Bench for weight_stream_fetcher: a table of fetch commands with hand-computed
// first/last words, plus hand-written reset sequences.
module tb_weight_stream_fetcher;
    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_layer;
    logic [17:0] cmd_base;
    logic [17:0] cmd_len;
    logic [5:0]  mem_layer_select;
    logic [17:0] mem_addr;
    logic [7:0]  mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    weight_stream_fetcher #(
        .DATA_WIDTH(8), .ADDR_WIDTH(18), .LAYER_WIDTH(6), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_layer(cmd_layer), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .mem_layer_select(mem_layer_select), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM content: low address byte plus 7 * layer (mod 256).
    function automatic logic [7:0] rom_fn(input logic [5:0] l, input logic [17:0] a);
        return 8'(a[7:0] + 8'(l) * 8'd7);
    endfunction

    // ROM bank model: registered address, combinational layer mux.
    logic [17:0] rom_addr_q;
    always @(posedge clk) rom_addr_q <= mem_addr;
    assign mem_data = rom_fn(mem_layer_select, rom_addr_q);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  layer;
        logic [17:0] base;
        logic [17:0] len;
        int          mode;       // 0 ready high, 1 ten-cycle stall, 2 random ready
        bit          chk_addr;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
        int          done_cyc;   // cycle (after handshake edge) done is seen; -1 = unchecked
        logic [17:0] stall_addr;
    } vec_t;

    vec_t tbl[6];

    // Starts at a falling edge; returns at the falling edge of the done cycle.
    task automatic run_cmd(input vec_t v);
        int         got;
        int         dones;
        int         cyc;
        int         stall_left;
        bit         seen;
        bit         fin;
        logic [7:0] held;
        logic [7:0] first_d;
        logic [7:0] last_d;
        logic       exp_l;
        got = 0; dones = 0; cyc = 0; stall_left = 0; seen = 0; fin = 0;
        held = '0; first_d = '0; last_d = '0;
        cmd_layer = v.layer; cmd_base = v.base; cmd_len = v.len; cmd_valid = 1'b1;
        check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (1) begin
            case (v.mode)
                1: begin
                    if (!seen && out_valid) begin
                        seen = 1; stall_left = 10; held = out_data;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                        if (stall_left == 0) begin
                            check("stall_addr", 32'(mem_addr), 32'(v.stall_addr));
                            check("stall_hold_data", 32'(out_data), 32'(held));
                            check("stall_valid", 32'(out_valid), 32'd1);
                        end
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            if (v.chk_addr && cyc < int'(v.len))
                check("mem_addr_seq", 32'(mem_addr), 32'(18'(v.base + 18'(cyc))));
            if (busy)
                check("layer_hold", 32'(mem_layer_select), 32'(v.layer));
            if (done) begin
                dones++;
                if (got == int'(v.len)) fin = 1;
            end
            if (out_valid && out_ready) begin
                exp_l = (18'(got) == v.len - 18'd1);
                check("out_data", 32'(out_data), 32'(rom_fn(v.layer, 18'(v.base + 18'(got)))));
                check("out_last", 32'(out_last), 32'(exp_l));
                if (got == 0) first_d = out_data;
                last_d = out_data;
                got++;
            end
            if (fin) break;
            if (cyc >= 400) begin
                check("cmd_timeout", 32'(got), 32'(v.len));
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("words_received", 32'(got), 32'(v.len));
        check("done_pulses", 32'(dones), 32'd1);
        if (fin) begin
            check("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
            check("busy_after_done", 32'(busy), 32'd0);
            if (v.done_cyc >= 0) check("done_cycle", 32'(cyc), 32'(v.done_cyc));
        end
        if (v.len != '0) begin
            check("first_word", 32'(first_d), 32'(v.exp_first));
            check("last_word", 32'(last_d), 32'(v.exp_last));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_layer"}, 32'(mem_layer_select), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   pops;
        int   dn;
        vec_t post;
        tbl[0] = '{6'd16, 18'h00000, 18'd5,  0, 1'b1, 8'h70, 8'h74, 7,  18'h0};
        tbl[1] = '{6'd16, 18'h00000, 18'd5,  1, 1'b0, 8'h70, 8'h74, -1, 18'h4};
        tbl[2] = '{6'd3,  18'h00064, 18'd0,  0, 1'b0, 8'h00, 8'h00, 0,  18'h0};
        tbl[3] = '{6'd4,  18'h3FFFE, 18'd4,  0, 1'b1, 8'h1A, 8'h1D, 6,  18'h0};
        tbl[4] = '{6'd9,  18'h00200, 18'd64, 2, 1'b0, 8'h3F, 8'h7E, -1, 18'h0};
        tbl[5] = '{6'd2,  18'h00010, 18'd3,  0, 1'b1, 8'h1E, 8'h20, 5,  18'h0};
        post   = '{6'd7,  18'h00020, 18'd4,  0, 1'b1, 8'h51, 8'h54, 6,  18'h0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_layer = '0; cmd_base = '0; cmd_len = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table commands run back to back: each next command is presented in
        // the done cycle of the previous one.
        for (int i = 0; i < 6; i++) run_cmd(tbl[i]);

        // Reset in the middle of a fetch, after three words were delivered.
        cmd_layer = 6'd5; cmd_base = 18'h00040; cmd_len = 18'd8; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; out_ready = 1'b1; pops = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) pops++;
            if (pops == 3) break;
            @(negedge clk);
        end
        check("mid_pops", 32'(pops), 32'd3);
        @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || out_valid) dn++;
        end
        check("post_reset_quiet", 32'(dn), 32'd0);
        run_cmd(post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
